// File: rtl/inst_fetch_mod.sv
// Instruction prefetch unit: fetches bytes over a req/ack bus into a small FIFO
// and presents the head opcode (CB-prefix aware) plus raw immediate bytes.
module inst_fetch_mod #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] mem_addr,
  output logic        mem_rd_req,
  input  logic        mem_rd_ack,
  input  logic [7:0]  mem_rd_data,
  output logic        inst_valid,
  output logic [8:0]  inst_opcode,
  input  logic        inst_take,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  input  logic        byte_take,
  input  logic        pc_load,
  input  logic [15:0] pc_in,
  output logic [15:0] inst_pc
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE   = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_TWO   = CW'(2);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DRAIN = 2'd2} state_t;

  state_t        state_r, state_next;
  logic [7:0]    fifo_r [DEPTH];
  logic [PW-1:0] rd_ptr_r, wr_ptr_r;
  logic [CW-1:0] count_r, count_after_pop_s;
  logic [15:0]   fetch_addr_r, head_pc_r, addr_r;
  logic          req_r;
  logic [7:0]    head_s, next_s;
  logic          head_is_cb_s, inst_valid_s, byte_valid_s, push_s, issue_s;
  logic [1:0]    pop_s;

  // Fetch FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= state_next;
  end

  // Fetch FSM next-state logic; a redirect while a request is in flight
  // must still wait out the ack, hence DRAIN
  always_comb begin
    state_next = state_r;
    case (state_r)
      IDLE: begin
        if (issue_s) state_next = REQ;
        else         state_next = IDLE;
      end
      REQ: begin
        if (mem_rd_ack)   state_next = IDLE;
        else if (pc_load) state_next = DRAIN;
        else              state_next = REQ;
      end
      DRAIN: begin
        if (mem_rd_ack) state_next = IDLE;
        else            state_next = DRAIN;
      end
      default: state_next = IDLE;
    endcase
  end

  // Head decode, pop sizing and push/issue qualifiers
  always_comb begin
    head_s       = fifo_r[rd_ptr_r];
    next_s       = fifo_r[rd_ptr_r + PTR_ONE];
    head_is_cb_s = (head_s == 8'hCB);
    byte_valid_s = (count_r != '0);
    if (head_is_cb_s) inst_valid_s = (count_r >= CNT_TWO);
    else              inst_valid_s = byte_valid_s;
    if (pc_load)                          pop_s = 2'd0;
    else if (inst_take && inst_valid_s)   pop_s = head_is_cb_s ? 2'd2 : 2'd1;
    else if (byte_take && byte_valid_s)   pop_s = 2'd1;
    else                                  pop_s = 2'd0;
    count_after_pop_s = count_r - CW'(pop_s);
    push_s  = (state_r == REQ) && mem_rd_ack && !pc_load;
    issue_s = (state_r == IDLE) && !pc_load && (count_after_pop_s < CNT_DEPTH);
  end

  // FIFO storage, pointers, head/fetch addresses and the registered bus request
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) fifo_r[i] <= 8'h00;
      rd_ptr_r     <= '0;
      wr_ptr_r     <= '0;
      count_r      <= '0;
      fetch_addr_r <= RESET_PC;
      head_pc_r    <= RESET_PC;
      addr_r       <= RESET_PC;
      req_r        <= 1'b0;
    end else begin
      req_r <= (state_next != IDLE);
      if (issue_s) addr_r <= fetch_addr_r;
      if (pc_load) begin
        rd_ptr_r     <= '0;
        wr_ptr_r     <= '0;
        count_r      <= '0;
        fetch_addr_r <= pc_in;
        head_pc_r    <= pc_in;
      end else begin
        if (push_s) begin
          fifo_r[wr_ptr_r] <= mem_rd_data;
          wr_ptr_r         <= wr_ptr_r + PTR_ONE;
          fetch_addr_r     <= fetch_addr_r + 16'd1;
        end
        rd_ptr_r  <= rd_ptr_r + PW'(pop_s);
        count_r   <= count_r + CW'(push_s) - CW'(pop_s);
        head_pc_r <= head_pc_r + 16'(pop_s);
      end
    end
  end

  assign mem_rd_req  = req_r;
  assign mem_addr    = addr_r;
  assign inst_valid  = inst_valid_s;
  assign inst_opcode = inst_valid_s ? {head_is_cb_s, (head_is_cb_s ? next_s : head_s)} : 9'h000;
  assign byte_valid  = byte_valid_s;
  assign byte_data   = byte_valid_s ? head_s : 8'h00;
  assign inst_pc     = head_pc_r;

endmodule

// File: tb/tb_inst_fetch_mod.sv
// Bench for inst_fetch_mod: directed scenarios then random traffic, all checked
// against a byte-queue reference model of the prefetch buffer.
module tb_inst_fetch_mod;
  localparam int          DEPTH    = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] mem_addr;
  logic        mem_rd_req, mem_rd_ack;
  logic [7:0]  mem_rd_data;
  logic        inst_valid, byte_valid;
  logic [8:0]  inst_opcode;
  logic [7:0]  byte_data;
  logic        inst_take = 1'b0, byte_take = 1'b0, pc_load = 1'b0;
  logic [15:0] pc_in = 16'h0000;
  logic [15:0] inst_pc;

  logic [7:0]  mem [0:65535];
  int          ack_delay = 0;
  int          wcnt;

  logic [7:0]  q[$];
  logic [15:0] m_pc, m_fetch, m_addr;
  bit          m_req, m_drain;
  int          n_assert = 0, n_fail = 0;

  inst_fetch_mod #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset(reset), .mem_addr(mem_addr), .mem_rd_req(mem_rd_req),
    .mem_rd_ack(mem_rd_ack), .mem_rd_data(mem_rd_data), .inst_valid(inst_valid),
    .inst_opcode(inst_opcode), .inst_take(inst_take), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_take(byte_take), .pc_load(pc_load),
    .pc_in(pc_in), .inst_pc(inst_pc)
  );

  always #5 clock = ~clock;

  // Memory responder: ack after ack_delay wait cycles, data from the array
  always @(posedge clock or negedge reset) begin
    if (!reset)                        wcnt <= 0;
    else if (mem_rd_req && !mem_rd_ack) wcnt <= wcnt + 1;
    else                               wcnt <= 0;
  end
  assign mem_rd_ack  = mem_rd_req && (wcnt >= ack_delay);
  assign mem_rd_data = mem_rd_ack ? mem[mem_addr] : 8'h00;

  function automatic bit m_iv();
    if (q.size() == 0)       return 1'b0;
    else if (q[0] == 8'hCB)  return q.size() >= 2;
    else                     return 1'b1;
  endfunction

  function automatic logic [8:0] m_op();
    if (!m_iv())            return 9'h000;
    else if (q[0] == 8'hCB) return {1'b1, q[1]};
    else                    return {1'b0, q[0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    q.delete();
    m_pc = RESET_PC; m_fetch = RESET_PC; m_addr = RESET_PC;
    m_req = 1'b0; m_drain = 1'b0;
  endtask

  task automatic check_all();
    chk("mem_rd_req",  32'(mem_rd_req),  32'(m_req));
    chk("mem_addr",    32'(mem_addr),    32'(m_addr));
    chk("inst_valid",  32'(inst_valid),  32'(m_iv()));
    chk("inst_opcode", 32'(inst_opcode), 32'(m_op()));
    chk("byte_valid",  32'(byte_valid),  32'(q.size() != 0));
    chk("byte_data",   32'(byte_data),   32'((q.size() != 0) ? q[0] : 8'h00));
    chk("inst_pc",     32'(inst_pc),     32'(m_pc));
  endtask

  // One clock: drive inputs, update the model from mid-cycle bus values, check after the edge
  task automatic cycle(input bit it, input bit bt, input bit pl, input logic [15:0] pin);
    int npop;
    bit ack;
    inst_take = it; byte_take = bt; pc_load = pl; pc_in = pin;
    @(negedge clock);
    ack  = mem_rd_ack;
    npop = 0;
    if (!pl) begin
      if (it && m_iv())             npop = (q[0] == 8'hCB) ? 2 : 1;
      else if (bt && q.size() != 0) npop = 1;
    end
    for (int i = 0; i < npop; i++) void'(q.pop_front());
    m_pc = m_pc + 16'(npop);
    if (pl) begin
      q.delete();
      m_pc = pin; m_fetch = pin;
      m_drain = m_req && !ack;
    end else if (m_req && ack) begin
      if (m_drain) m_drain = 1'b0;
      else begin
        q.push_back(mem[m_fetch]);
        m_fetch = m_fetch + 16'd1;
      end
    end
    if (m_req) m_req = !ack;
    else if (!pl && q.size() < DEPTH) begin
      m_req = 1'b1; m_addr = m_fetch;
    end
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[0] = 8'h00; mem[1] = 8'h3E; mem[2] = 8'h42; mem[3] = 8'hCB; mem[4] = 8'h37;
    mem[5] = 8'h01; mem[6] = 8'h02; mem[7] = 8'h03; mem[8] = 8'h04;
    mem[16'h0200] = 8'hCB; mem[16'h0201] = 8'h37;
    m_reset();
    #1 reset = 1'b0;
    #1 check_all();
    #5 reset = 1'b1;

    // zero-wait fetch from reset release, fill to DEPTH
    cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    chk("sc1_req_edge1",  32'(mem_rd_req), 32'd1);
    chk("sc1_addr_edge1", 32'(mem_addr),   32'h0000);
    cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    chk("sc1_valid_edge2", 32'(inst_valid),  32'd1);
    chk("sc1_op_edge2",    32'(inst_opcode), 32'h000);
    idle(8);
    chk("sc1_full_noreq", 32'(mem_rd_req), 32'd0);

    // opcode, immediate, CB pair, simultaneous takes
    cycle(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("sc3_op3e", 32'(inst_opcode), 32'h03E);
    cycle(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("sc3_imm42", 32'(byte_data), 32'h42);
    cycle(1'b0, 1'b1, 1'b0, 16'h0000);
    chk("sc3_pc_byte", 32'(inst_pc),     32'h0003);
    chk("sc2_op137",   32'(inst_opcode), 32'h137);
    cycle(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("sc2_pc_cb", 32'(inst_pc), 32'h0005);
    cycle(1'b1, 1'b1, 1'b0, 16'h0000);
    chk("sc3_both_takes", 32'(inst_pc), 32'h0006);

    // CB alone is not an instruction yet
    cycle(1'b0, 1'b0, 1'b1, 16'h0200);
    ack_delay = 3;
    idle(5);
    chk("sc2_cb_only_iv", 32'(inst_valid), 32'd0);
    chk("sc2_cb_only_bv", 32'(byte_valid), 32'd1);
    idle(5);
    chk("sc2_cb37", 32'(inst_opcode), 32'h137);
    cycle(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("sc2_pc_0202", 32'(inst_pc), 32'h0202);

    // redirect on the first wait cycle of an outstanding request
    cycle(1'b0, 1'b0, 1'b1, 16'h0150);
    chk("sc4_drain_req",  32'(mem_rd_req), 32'd1);
    chk("sc4_drain_addr", 32'(mem_addr),   32'h0202);
    chk("sc4_pc",         32'(inst_pc),    32'h0150);
    idle(4);
    chk("sc4_newreq_addr", 32'(mem_addr),   32'h0150);
    chk("sc4_newreq",      32'(mem_rd_req), 32'd1);

    // address wrap FFFF -> 0000
    ack_delay = 0;
    mem[16'hFFFF] = 8'h00; mem[16'h0000] = 8'hC3;
    cycle(1'b0, 1'b0, 1'b1, 16'hFFFF);
    idle(4);
    chk("sc5_pc_ffff", 32'(inst_pc), 32'hFFFF);
    cycle(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("sc5_pc_0000", 32'(inst_pc),     32'h0000);
    chk("sc5_op_c3",   32'(inst_opcode), 32'h0C3);

    // asynchronous reset in the middle of a request
    chk("sc6_pre_req", 32'(mem_rd_req), 32'd1);
    #1 reset = 1'b0;
    #1;
    m_reset();
    check_all();
    #1 reset = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    chk("sc6_refetch_addr", 32'(mem_addr),   32'(RESET_PC));
    chk("sc6_refetch_req",  32'(mem_rd_req), 32'd1);

    // random traffic
    for (int i = 0; i < 65536; i++)
      mem[i] = ($urandom_range(0, 3) == 0) ? 8'hCB : 8'($urandom);
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] tgt;
      ack_delay = $urandom_range(0, 3);
      tgt = ($urandom_range(0, 3) == 0) ? (16'hFFFC + 16'($urandom_range(0, 3))) : 16'($urandom);
      cycle(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 29) == 0), tgt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
